mem_responder: RTL and testbench

Clocked memory responder that services store/retrieve requests from an initiator, such as the DPI-C driven memory model driver, over a valid/ready request channel and a valid/ready response channel. It holds a word-addressed storage array and inserts a programmable number of wait cycles per access, so initiator-side tasks consume simulated clock time. Exactly one transaction is outstanding at a time.

---
 rtl/mem_responder_pkg.sv | 10 +
 rtl/mem_responder_ram.sv | 25 ++
 rtl/mem_responder.sv | 126 ++++++++++++
 tb/tb_mem_responder.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared types and defaults for the memory responder and its DPI-side driver.
package mem_responder_pkg;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

   localparam int DEF_ADDR_W = 32;   // C-side int
   localparam int DEF_DATA_W = 16;   // C-side shortint
   localparam int LAT_W      = 4;

endpackage

// File: rtl/mem_responder_ram.sv
// Single-port storage: synchronous write, registered read, no reset so it maps to RAM.
module mem_responder_ram #(
   parameter int DEPTH  = 256,
   parameter int DATA_W = 16,
   parameter int IDX_W  = 8
) (
   input  logic              clk,
   input  logic              we,
   input  logic              re,
   input  logic [IDX_W-1:0]  addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we) mem_q[addr] <= wdata;
      if (re) rdata_q <= mem_q[addr];
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder with programmable wait cycles per access.
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int DEPTH   = 256,
   parameter int LATENCY = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_write,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0]  DEPTH_X  = (ADDR_W+1)'(DEPTH);
   localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'((LATENCY > 0) ? LATENCY - 1 : 0);

   state_e             state_q, state_d;
   logic [LAT_W-1:0]   cnt_q, cnt_d;
   logic               write_q, write_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [DATA_W-1:0]  wdata_q, wdata_d;
   logic               rsp_write_q, rsp_write_d;
   logic               rsp_err_q, rsp_err_d;
   logic               rd_ok_q, rd_ok_d;

   logic               accept, access, acc_write, in_range;
   logic [ADDR_W-1:0]  acc_addr;
   logic [DATA_W-1:0]  acc_wdata;
   logic [DATA_W-1:0]  ram_rdata;

   // With zero latency the access happens on the accept edge, so it uses the live request.
   always_comb begin
      accept = (state_q == IDLE) && req_valid;
      if (LATENCY == 0) begin
         access    = accept;
         acc_write = req_write;
         acc_addr  = req_addr;
         acc_wdata = req_wdata;
      end else begin
         access    = (state_q == WAIT) && (cnt_q == '0);
         acc_write = write_q;
         acc_addr  = addr_q;
         acc_wdata = wdata_q;
      end
      in_range = {1'b0, acc_addr} < DEPTH_X;
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      write_d     = write_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rsp_write_d = rsp_write_q;
      rsp_err_d   = rsp_err_q;
      rd_ok_d     = rd_ok_q;
      case (state_q)
         IDLE: if (accept) begin
            write_d = req_write;
            addr_d  = req_addr;
            wdata_d = req_wdata;
            cnt_d   = LAT_LOAD;
            state_d = (LATENCY == 0) ? RESP : WAIT;
         end
         WAIT: if (cnt_q == '0) state_d = RESP;
               else cnt_d = cnt_q - 1'b1;
         RESP: if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (access) begin
         rsp_write_d = acc_write;
         rsp_err_d   = !in_range;
         rd_ok_d     = !acc_write && in_range;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         write_q     <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rsp_write_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rd_ok_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         write_q     <= write_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rsp_write_q <= rsp_write_d;
         rsp_err_q   <= rsp_err_d;
         rd_ok_q     <= rd_ok_d;
      end
   end

   // Reset gates the write so an aborted store can never land in the array.
   mem_responder_ram #(.DEPTH(DEPTH), .DATA_W(DATA_W), .IDX_W(IDX_W)) u_ram (
      .clk   (clk),
      .we    (access && acc_write && in_range && !rst),
      .re    (access && !acc_write && in_range),
      .addr  (acc_addr[IDX_W-1:0]),
      .wdata (acc_wdata),
      .rdata (ram_rdata)
   );

   assign req_ready = (state_q == IDLE);
   assign rsp_valid = (state_q == RESP);
   assign rsp_write = rsp_write_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_rdata = rd_ok_q ? ram_rdata : '0;

endmodule

// File: tb/tb_mem_responder.sv
// Directed scoreboard bench for mem_responder at LATENCY=2 and LATENCY=0.
module tb_mem_responder;

   typedef struct packed {
      logic        w;
      logic [15:0] rdata;
      logic        err;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, req_valid, req_write, rsp_ready;
   logic [31:0] req_addr;
   logic [15:0] req_wdata;
   logic        req_ready, rsp_valid, rsp_write, rsp_err;
   logic [15:0] rsp_rdata;

   logic        rst0, req_valid0, req_write0, rsp_ready0;
   logic [31:0] req_addr0;
   logic [15:0] req_wdata0;
   logic        req_ready0, rsp_valid0, rsp_write0, rsp_err0;
   logic [15:0] rsp_rdata0;

   int   errors = 0;
   int   checks = 0;
   exp_t sb[$];

   mem_responder #(.ADDR_W(32), .DATA_W(16), .DEPTH(256), .LATENCY(2)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
   );

   mem_responder #(.ADDR_W(32), .DATA_W(16), .DEPTH(256), .LATENCY(0)) dut0 (
      .clk(clk), .rst(rst0), .req_valid(req_valid0), .req_ready(req_ready0),
      .req_write(req_write0), .req_addr(req_addr0), .req_wdata(req_wdata0),
      .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0), .rsp_write(rsp_write0),
      .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drive a request on dut and return just after its accept edge.
   task automatic send(input logic w, input logic [31:0] a, input logic [15:0] d,
                       input logic [15:0] er, input logic ee);
      int n = 0;
      req_write = w; req_addr = a; req_wdata = d; req_valid = 1'b1;
      while (!req_ready && n < 50) begin step(); n++; end
      chk("accept_timeout", n < 50, 1);
      step();
      req_valid = 1'b0;
      sb.push_back('{w: w, rdata: er, err: ee});
   endtask

   // Wait for dut's response, compare against the scoreboard, hold bp cycles, then handshake.
   task automatic expect_rsp(input int bp);
      int   n = 0;
      exp_t e;
      while (!rsp_valid && n < 20) begin
         chk("busy_req_ready", req_ready, 0);
         step(); n++;
      end
      chk("rsp_latency", n, 2);
      e = sb.pop_front();
      chk("rsp_write", rsp_write, e.w);
      chk("rsp_rdata", rsp_rdata, e.rdata);
      chk("rsp_err", rsp_err, e.err);
      for (int i = 0; i < bp; i++) begin
         step();
         chk("bp_valid", rsp_valid, 1);
         chk("bp_rdata", rsp_rdata, e.rdata);
         chk("bp_req_ready", req_ready, 0);
      end
      rsp_ready = 1'b1;
      step();
      chk("post_hs_valid", rsp_valid, 0);
      chk("post_hs_ready", req_ready, 1);
   endtask

   task automatic txn(input logic w, input logic [31:0] a, input logic [15:0] d,
                      input logic [15:0] er, input logic ee, input int bp);
      rsp_ready = (bp == 0);
      send(w, a, d, er, ee);
      expect_rsp(bp);
   endtask

   task automatic txn0(input logic w, input logic [31:0] a, input logic [15:0] d,
                       input logic [15:0] er, input logic ee);
      int   n = 0;
      exp_t e;
      req_write0 = w; req_addr0 = a; req_wdata0 = d; req_valid0 = 1'b1;
      while (!req_ready0 && n < 20) begin step(); n++; end
      chk("l0_accept_timeout", n < 20, 1);
      step();
      req_valid0 = 1'b0;
      sb.push_back('{w: w, rdata: er, err: ee});
      chk("l0_rsp_valid", rsp_valid0, 1);
      e = sb.pop_front();
      chk("l0_rsp_write", rsp_write0, e.w);
      chk("l0_rsp_rdata", rsp_rdata0, e.rdata);
      chk("l0_rsp_err", rsp_err0, e.err);
      step();
      chk("l0_post_valid", rsp_valid0, 0);
      chk("l0_post_ready", req_ready0, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
      rst0 = 1'b1; req_valid0 = 1'b0; req_write0 = 1'b0; req_addr0 = '0; req_wdata0 = '0; rsp_ready0 = 1'b1;
      repeat (3) step();
      chk("rst_req_ready", req_ready, 1);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_write", rsp_write, 0);
      chk("rst_rsp_rdata", rsp_rdata, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst0_req_ready", req_ready0, 1);
      chk("rst0_rsp_valid", rsp_valid0, 0);
      rst = 1'b0; rst0 = 1'b0;
      step();

      // store then retrieve
      txn(1, 100, 16'd1024, 16'h0, 0, 0);
      txn(0, 100, 16'h0, 16'd1024, 0, 0);

      // response backpressure
      txn(1, 7, 16'h00A5, 16'h0, 0, 0);
      txn(0, 7, 16'h0, 16'h00A5, 0, 5);

      // out-of-range, including an address that aliases 100 if truncated
      txn(1, 44, 16'h1234, 16'h0, 0, 0);
      txn(1, 300, 16'hBEEF, 16'h0, 1, 0);
      txn(0, 300, 16'h0, 16'h0, 1, 0);
      txn(0, 44, 16'h0, 16'h1234, 0, 0);
      txn(1, 32'h0001_0064, 16'h7777, 16'h0, 1, 0);
      txn(0, 32'h0001_0064, 16'h0, 16'h0, 1, 0);
      txn(0, 100, 16'h0, 16'd1024, 0, 0);
      txn(0, 255, 16'h0, 16'h0, 0, 0);
      txn(0, 256, 16'h0, 16'h0, 1, 0);

      // reset during WAIT
      txn(1, 10, 16'h1111, 16'h0, 0, 0);
      req_write = 1'b1; req_addr = 10; req_wdata = 16'h5555; req_valid = 1'b1;
      chk("rstw_ready", req_ready, 1);
      step();
      req_valid = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rstw_rsp_write", rsp_write, 0);
      chk("rstw_rsp_err", rsp_err, 0);
      for (int i = 0; i < 6; i++) begin
         chk("rstw_no_valid", rsp_valid, 0);
         chk("rstw_idle", req_ready, 1);
         step();
      end
      txn(0, 10, 16'h0, 16'h1111, 0, 0);

      // requests while busy: second request held valid across the first response
      rsp_ready = 1'b1;
      req_write = 1'b0; req_addr = 100; req_wdata = '0; req_valid = 1'b1;
      chk("busy_first_ready", req_ready, 1);
      step();
      sb.push_back('{w: 1'b0, rdata: 16'd1024, err: 1'b0});
      req_write = 1'b1; req_addr = 55; req_wdata = 16'h4242;
      expect_rsp(0);
      step();
      chk("busy_second_accepted", req_ready, 0);
      req_valid = 1'b0;
      sb.push_back('{w: 1'b1, rdata: 16'h0, err: 1'b0});
      expect_rsp(0);
      txn(0, 55, 16'h0, 16'h4242, 0, 0);

      // LATENCY=0 build, back to back
      txn0(1, 0, 16'hFFFF, 16'h0, 0);
      txn0(0, 0, 16'h0, 16'hFFFF, 0);
      txn0(0, 300, 16'h0, 16'h0, 1);

      chk("scoreboard_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
